// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for a single-port data memory, with bounded lock bursts
// and one-cycle registered read return.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_arbiter_if.slave      bus
);
  localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] BeatLast = CW'(LOCK_MAX - 1);

  logic          last_owner_q, last_owner_d;
  logic          lock_active_q, lock_active_d;
  logic          lock_owner_q, lock_owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic [1:0] req, lock, we;
  logic       owner_holds, forced, gnt_any, gnt_idx, continuing;
  logic [1:0] gnt;

  assign req  = {bus.m1_req, bus.m0_req};
  assign lock = {bus.m1_lock, bus.m0_lock};
  assign we   = {bus.m1_we, bus.m0_we};

  // Owner keeps the bus unless it has used its full burst and the other master is waiting.
  assign owner_holds = lock_active_q & req[lock_owner_q] & lock[lock_owner_q];
  assign forced      = owner_holds & (beat_cnt_q == BeatLast) & req[~lock_owner_q];

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (!rst_n) begin
      gnt_any = 1'b0;
    end else if (owner_holds && !forced) begin
      gnt_any = 1'b1;
      gnt_idx = lock_owner_q;
    end else if (req == 2'b11) begin
      gnt_any = 1'b1;
      gnt_idx = ~last_owner_q;
    end else if (req[0]) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b0;
    end else if (req[1]) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  assign gnt = {gnt_any & gnt_idx, gnt_any & ~gnt_idx};

  always_comb begin
    last_owner_d  = last_owner_q;
    lock_active_d = 1'b0;
    lock_owner_d  = lock_owner_q;
    beat_cnt_d    = '0;
    continuing    = lock_active_q & (lock_owner_q == gnt_idx);
    if (gnt_any) begin
      last_owner_d = gnt_idx;
      if (lock[gnt_idx] && !forced) begin
        lock_active_d = 1'b1;
        lock_owner_d  = gnt_idx;
        if (continuing) begin
          beat_cnt_d = (beat_cnt_q == BeatLast) ? beat_cnt_q : beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      beat_cnt_q    <= '0;
      rvalid_q      <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      last_owner_q  <= last_owner_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      beat_cnt_q    <= beat_cnt_d;
      rvalid_q      <= gnt & ~we;
      if (gnt[0] && !we[0]) rdata0_q <= bus.mem_rd;
      if (gnt[1] && !we[1]) rdata1_q <= bus.mem_rd;
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

  assign bus.mem_we   = gnt_any & we[gnt_idx];
  assign bus.mem_addr = gnt[1] ? bus.m1_addr : bus.m0_addr;
  assign bus.mem_wd   = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of per-cycle vectors plus reset and lock-burst sequences.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  assign bus.mem_rd = mem[bus.mem_addr[5:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1;
    logic        g0, g1, mwe, v0, v1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, w0, l0, input logic [31:0] a0, d0,
                              input logic r1, input logic [31:0] a1,
                              input logic g0, g1, mwe, v0, v1,
                              input logic [31:0] rd0, rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = 1'b0; v.l1 = 1'b0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [31:0] a0, d0,
                       input logic r1, l1, input logic [31:0] a1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = 1'b0; bus.m1_lock = l1; bus.m1_addr = a1;
    bus.m1_wdata = 32'h0;
  endtask

  localparam logic [31:0] A0 = 32'h000000A0;
  localparam logic [31:0] B1 = 32'h000000B1;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] WV = 32'h12345678;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = A0;
    mem[1] = B1;
    mem[4] = DB;

    // Reset held with both masters requesting, m0 trying to write.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 1'b1, 1'b0, 32'h4);
    repeat (2) @(negedge clk);
    #1;
    check("rst gnt0", {31'h0, bus.m0_gnt}, 32'h0);
    check("rst gnt1", {31'h0, bus.m1_gnt}, 32'h0);
    check("rst mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst rvalid0", {31'h0, bus.m0_rvalid}, 32'h0);
    check("rst rvalid1", {31'h0, bus.m1_rvalid}, 32'h0);
    check("rst rdata0", bus.m0_rdata, 32'h0);
    check("rst rdata1", bus.m1_rdata, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4);
    rst_n = 1'b1;
    #1;
    check("release gnt0", {31'h0, bus.m0_gnt}, 32'h1);
    check("release gnt1", {31'h0, bus.m1_gnt}, 32'h0);

    // r0 w0 l0 a0 d0 r1 a1 | g0 g1 mwe v0 v1 rd0 rd1
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10, 0, 1, 0, 1, 0, A0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, A0, DB));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, A0, DB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      1, 0, 0, 0, 0, A0, DB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      0, 1, 0, 1, 0, A0, DB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      1, 0, 0, 0, 1, A0, B1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      0, 1, 0, 1, 0, A0, B1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      1, 0, 0, 0, 1, A0, B1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4,      0, 1, 0, 1, 0, A0, B1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, A0, B1));
    vecs.push_back(mk(1, 1, 0, 8, WV, 1, 8,     1, 0, 1, 0, 0, A0, B1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8,      0, 1, 0, 0, 0, A0, B1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, A0, WV));
    // m0 locked vs waiting m1 with a 4-beat bound
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      1, 0, 0, 0, 0, A0, WV));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      1, 0, 0, 1, 0, A0, WV));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      1, 0, 0, 1, 0, A0, WV));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      1, 0, 0, 1, 0, A0, WV));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      0, 1, 0, 1, 0, A0, WV));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 4,      1, 0, 0, 0, 1, A0, B1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, A0, B1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].l1, vecs[i].a1);
      #1;
      check($sformatf("v%0d gnt0", i), {31'h0, bus.m0_gnt}, {31'h0, vecs[i].g0});
      check($sformatf("v%0d gnt1", i), {31'h0, bus.m1_gnt}, {31'h0, vecs[i].g1});
      check($sformatf("v%0d mem_we", i), {31'h0, bus.mem_we}, {31'h0, vecs[i].mwe});
      check($sformatf("v%0d rvalid0", i), {31'h0, bus.m0_rvalid}, {31'h0, vecs[i].v0});
      check($sformatf("v%0d rvalid1", i), {31'h0, bus.m1_rvalid}, {31'h0, vecs[i].v1});
      check($sformatf("v%0d rdata0", i), bus.m0_rdata, vecs[i].rd0);
      check($sformatf("v%0d rdata1", i), bus.m1_rdata, vecs[i].rd1);
    end
    check("write landed", mem[2], WV);

    // Lone locked owner: beat count saturates, then a late m1 request is served at once.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4);
      #1;
      check($sformatf("sat c%0d gnt0", c), {31'h0, bus.m0_gnt}, 32'h1);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4);
    #1;
    check("sat release gnt1", {31'h0, bus.m1_gnt}, 32'h1);
    @(negedge clk);
    #1;
    check("sat resume gnt0", {31'h0, bus.m0_gnt}, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4);
    #1;
    check("burst gnt0", {31'h0, bus.m0_gnt}, 32'h1);

    // Reset mid locked read burst, just after a read return.
    @(posedge clk);
    #1;
    check("pre-rst rvalid0", {31'h0, bus.m0_rvalid}, 32'h1);
    bus.m0_we = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst rvalid0", {31'h0, bus.m0_rvalid}, 32'h0);
    check("midrst rdata0", bus.m0_rdata, 32'h0);
    check("midrst gnt0", {31'h0, bus.m0_gnt}, 32'h0);
    check("midrst gnt1", {31'h0, bus.m1_gnt}, 32'h0);
    check("midrst mem_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4);
    rst_n = 1'b1;
    #1;
    check("post-rst gnt0", {31'h0, bus.m0_gnt}, 32'h1);
    @(negedge clk);
    #1;
    check("post-rst gnt1", {31'h0, bus.m1_gnt}, 32'h1);
    check("post-rst rvalid0", {31'h0, bus.m0_rvalid}, 32'h1);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
